myproject_dense_acc: RTL and testbench

Accumulator stage downstream of the `myproject_mul_*` product units in a dense layer. It consumes one signed product per handshake and sums N_IN products per neuron output. It then adds a bias, rescales by an arithmetic right shift, and applies ReLU with saturation. The result is an unsigned activation in the width that the next layer's multiplier takes as its unsigned operand.

---
 rtl/myproject_dense_pkg.sv | 31 +++
 rtl/myproject_relu_sat.sv | 43 ++++
 rtl/myproject_dense_acc.sv | 133 +++++++++++++
 tb/tb_myproject_dense_acc.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/myproject_dense_pkg.sv
// Shared types and default widths for the dense-layer multiply/accumulate path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: accumulator FSM state enum, constant clog2 helper, default widths
// shared by the product units and the accumulator so the two stay consistent.
package myproject_dense_pkg;

  localparam int DENSE_PROD_W = 15;
  localparam int DENSE_ACC_W  = 20;
  localparam int DENSE_OUT_W  = 7;

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_BIAS = 2'd1,
    ST_OUT  = 2'd2
  } dense_acc_state_t;

  // Ceiling log2; clog2(1) = 0, so callers that need a counter clamp to 1 bit.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/myproject_relu_sat.sv
// Arithmetic right shift, ReLU and unsigned saturation of a signed sum.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows input.
// Ports: sum_in  [ACC_W-1:0] signed sum (bias already added)
//        act_out [OUT_W-1:0] unsigned activation, clamped to [0, 2^OUT_W-1]
module myproject_relu_sat #(
  parameter int ACC_W = 20,
  parameter int SHIFT = 6,
  parameter int OUT_W = 7
) (
  input  logic [ACC_W-1:0] sum_in,
  output logic [OUT_W-1:0] act_out
);

  // >>> on a signed operand floors negative values toward -inf.
  logic signed [ACC_W-1:0] shifted;
  assign shifted = $signed(sum_in) >>> SHIFT;

  generate
    if (ACC_W > OUT_W) begin : g_narrow
      // Any set bit above the output width (sign already excluded) means overflow.
      logic ovf;
      assign ovf = (shifted[ACC_W-1:OUT_W] != '0);

      always_comb begin
        act_out = shifted[OUT_W-1:0];
        if (shifted[ACC_W-1]) begin
          act_out = '0;
        end else if (ovf) begin
          act_out = '1;
        end
      end
    end else begin : g_wide
      always_comb begin
        act_out = OUT_W'($unsigned(shifted));
        if (shifted[ACC_W-1]) begin
          act_out = '0;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/myproject_dense_acc.sv
// Dense-layer accumulator: sums N_IN signed products, adds bias, shifts, ReLU+saturates.
// Latency: 2 cycles from the last accepted product to out_valid; N_IN+2 cycles per output.
// Backpressure: prod_ready low during BIAS and OUT; out_data held until out_ready.
// Ports: ap_clk/ap_rst (sync, active-high); prod_data/prod_valid/prod_ready product
//        input; bias (stable from last beat through BIAS); out_data/out_valid/out_ready.
module myproject_dense_acc
  import myproject_dense_pkg::*;
#(
  parameter int PROD_W = DENSE_PROD_W,
  parameter int N_IN   = 16,
  parameter int BIAS_W = 8,
  parameter int ACC_W  = DENSE_ACC_W,
  parameter int SHIFT  = 6,
  parameter int OUT_W  = DENSE_OUT_W
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [BIAS_W-1:0] bias,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W     = (clog2(N_IN) < 1) ? 1 : clog2(N_IN);
  localparam int SUM_W     = PROD_W + clog2(N_IN);
  localparam int MIN_ACC_W = ((SUM_W > BIAS_W) ? SUM_W : BIAS_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_IN - 1);

  generate
    if (N_IN < 1) begin : g_chk_n_in
      $error("myproject_dense_acc: N_IN must be >= 1");
    end
    if (ACC_W < MIN_ACC_W) begin : g_chk_acc_w
      $error("myproject_dense_acc: ACC_W too small for PROD_W, N_IN and BIAS_W");
    end
    if ((SHIFT < 0) || (SHIFT > ACC_W - 1)) begin : g_chk_shift
      $error("myproject_dense_acc: SHIFT must be in 0..ACC_W-1");
    end
  endgenerate

  dense_acc_state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             prod_ready_q, prod_ready_d;

  logic [ACC_W-1:0] prod_sext;
  logic [ACC_W-1:0] bias_sext;
  logic [ACC_W-1:0] biased_sum;
  logic [OUT_W-1:0] relu_out;
  logic             beat;

  assign prod_sext  = {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
  assign bias_sext  = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
  // ACC_W has headroom over both operands, so this add cannot overflow.
  assign biased_sum = acc_q + bias_sext;
  assign beat       = prod_valid & prod_ready_q;

  myproject_relu_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_relu_sat (
    .sum_in  (biased_sum),
    .act_out (relu_out)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_ACC: begin
        if (beat) begin
          acc_d = acc_q + prod_sext;
          // Hold cnt on the final beat; it only returns to 0 via the OUT handshake.
          if (cnt_q == LAST_CNT) begin
            state_d = ST_BIAS;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_BIAS: begin
        out_data_d  = relu_out;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = ST_ACC;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
    // Registered so prod_ready has no combinational path from any input.
    prod_ready_d = (state_d == ST_ACC);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= ST_ACC;
      acc_q        <= '0;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      prod_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      prod_ready_q <= prod_ready_d;
    end
  end

  assign prod_ready = prod_ready_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_myproject_dense_acc.sv
// Bench for myproject_dense_acc: directed product groups with hand-computed results.
// Expected activations go into a queue at stimulus time; a monitor pops on each output.
// Inputs change on the falling edge; outputs are sampled away from the rising edge.
module tb_myproject_dense_acc;

  logic       ap_clk;
  logic       ap_rst;
  logic [14:0] prod_data;
  logic       prod_valid;
  logic       prod_ready;
  logic [7:0] bias;
  logic [6:0] out_data;
  logic       out_valid;
  logic       out_ready;

  int exp_q[$];
  int n_checks;
  int n_fail;

  myproject_dense_acc dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .prod_data  (prod_data),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .bias       (bias),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one pop per accepted output.
  initial begin
    forever begin
      @(negedge ap_clk);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_output", exp_q.size(), 1);
        end else begin
          check("out_data", int'(out_data), exp_q.pop_front());
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send_beat(input int v, input int gap);
    int t;
    prod_valid = 1'b0;
    repeat (gap) @(negedge ap_clk);
    prod_data  = v[14:0];
    prod_valid = 1'b1;
    t = 0;
    while (!prod_ready && t < 200) begin
      @(negedge ap_clk);
      t++;
    end
    if (t >= 200) check("beat_accept_timeout", t, 0);
    @(negedge ap_clk);
    prod_valid = 1'b0;
  endtask

  task automatic send_group(input int v, input int exp);
    exp_q.push_back(exp);
    for (int i = 0; i < 16; i++) send_beat(v, 0);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge ap_clk);
      t++;
    end
    if (t >= 200) check("drain_timeout", t, 0);
    @(negedge ap_clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    ap_rst     = 1'b1;
    prod_valid = 1'b0;
    prod_data  = '0;
    bias       = 8'd0;
    out_ready  = 1'b1;

    // Reset values.
    repeat (3) @(negedge ap_clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_prod_ready", int'(prod_ready), 0);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("post_rst_prod_ready", int'(prod_ready), 1);

    // 16 x +100 -> 1600 >>> 6 = 25, with 2-cycle latency after the last beat.
    send_group(100, 25);
    check("bias_cycle_prod_ready", int'(prod_ready), 0);
    check("bias_cycle_out_valid", int'(out_valid), 0);
    @(negedge ap_clk);
    check("latency_out_valid", int'(out_valid), 1);
    check("out_cycle_prod_ready", int'(prod_ready), 0);
    @(negedge ap_clk);
    check("after_hs_out_valid", int'(out_valid), 0);
    check("after_hs_prod_ready", int'(prod_ready), 1);

    // Negative sum -> ReLU 0; bias-only results including floor of -1/64.
    send_group(-50, 0);
    wait_drain();
    bias = 8'd65;
    send_group(0, 1);
    wait_drain();
    bias = 8'hFF;
    send_group(0, 0);
    wait_drain();

    // Saturation: 262128 + 127 = 262255, >>> 6 = 4097 -> 127. Most negative products -> 0.
    bias = 8'd127;
    send_group(16383, 127);
    wait_drain();
    bias = 8'd0;
    send_group(-16384, 0);
    wait_drain();

    // Output stall: 16 x 32 = 512 -> 8, held while prod_valid pushes.
    out_ready = 1'b0;
    send_group(32, 8);
    @(negedge ap_clk);
    for (int i = 0; i < 10; i++) begin
      prod_data  = 15'd5000;
      prod_valid = 1'b1;
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_out_data", int'(out_data), 8);
      check("stall_prod_ready", int'(prod_ready), 0);
      @(negedge ap_clk);
    end
    prod_valid = 1'b0;
    out_ready  = 1'b1;
    wait_drain();
    // Independent result after the stall: 16 x 200 = 3200 -> 50.
    send_group(200, 50);
    wait_drain();

    // Random valid gaps, values 1..16: sum 136 -> 2.
    exp_q.push_back(2);
    for (int i = 1; i <= 16; i++) send_beat(i, $urandom_range(0, 5));
    wait_drain();

    // Reset mid-accumulation discards the partial sum.
    for (int i = 0; i < 7; i++) send_beat(1000, 0);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data", int'(out_data), 0);
    check("midrst_prod_ready", int'(prod_ready), 0);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("midrst_release_prod_ready", int'(prod_ready), 1);
    send_group(64, 16);
    wait_drain();

    check("sb_empty_at_end", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
